// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access width encodings, the data-bus
// adapter state enum, and the byte-strobe helper used for stores.
package mem_pkg;

  localparam logic [1:0] memWidth1 = 2'b00;
  localparam logic [1:0] memWidth2 = 2'b01;
  localparam logic [1:0] memWidth4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  // Byte strobes for a store of the given width at byte offset addr.
  // An undefined width encoding is treated as a full word.
  function automatic logic [3:0] wstrb_of(input logic [1:0] width,
                                          input logic [1:0] addr);
    logic [3:0] s;
    case (width)
      memWidth1: s = 4'b0001 << addr;
      memWidth2: s = addr[1] ? 4'b1100 : 4'b0011;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_bus_adapter_if.sv
// Valid/grant/response data bus between the adapter (master) and memory
// (slave).
//   bus_req/bus_wr/bus_addr/bus_wstrb/bus_wdata : request, master -> slave
//   bus_gnt                                     : request accepted this cycle
//   bus_rvalid/bus_rdata/bus_err                : response, slave -> master
interface dmem_bus_adapter_if;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/dmem_bus_adapter_load_extend.sv
// Combinational load-lane select and sign/zero extension.
//   width    : memWidth1/2/4
//   sign_ext : 1 = extend with lane MSB, 0 = zero-extend
//   addr     : byte offset within the word
//   raw      : word as returned by the bus
//   ext      : extended result
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        sign_ext,
  input  logic [1:0]  addr,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    b_lane = raw[{addr, 3'b000} +: 8];
    h_lane = addr[1] ? raw[31:16] : raw[15:0];
    case (width)
      memWidth1: ext = {{24{sign_ext & b_lane[7]}}, b_lane};
      memWidth2: ext = {{16{sign_ext & h_lane[15]}}, h_lane};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_bus_adapter.sv
// Data-memory bus stage. Captures one aligned load/store from MEM, runs a
// single request/grant/response transaction and returns extended load data.
//   clk, reset          : clock, async active-high reset
//   req_*               : request from MEM (req_valid low on address fault)
//   stall               : hold the pipeline while an op is outstanding
//   rdata_valid         : one-cycle completion pulse
//   rdata, err          : completion result, held until the next completion
//   bus                 : data bus, master side
module dmem_bus_adapter
  import mem_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255,
  parameter int TO_W         = 8     // 2**TO_W must exceed RESP_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_width,
  input  logic                req_sign_ext,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                stall,
  output logic                rdata_valid,
  output logic [31:0]         rdata,
  output logic                err,
  dmem_bus_adapter_if.master  bus
);

  dbus_state_t state_q, state_d;

  logic            cap_write;
  logic [1:0]      cap_width;
  logic            cap_sext;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     ld_ext;
  logic            to_hit;

  load_extend u_ext (
    .width    (cap_width),
    .sign_ext (cap_sext),
    .addr     (cap_addr[1:0]),
    .raw      (bus.bus_rdata),
    .ext      (ld_ext)
  );

  // Counter starts at 0 on the first RESP cycle, so RESP lasts at most
  // RESP_TIMEOUT cycles before the forced error completion.
  assign to_hit = (to_cnt == TO_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid)      state_d = REQ;
      REQ:  if (bus.bus_gnt)    state_d = RESP;
      RESP: if (bus.bus_rvalid) state_d = DONE;
            else if (to_hit)    state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_write <= 1'b0;
      cap_width <= 2'b00;
      cap_sext  <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      to_cnt    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_width <= req_width;
        cap_sext  <= req_sign_ext;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (state_q == REQ && bus.bus_gnt) to_cnt <= '0;
      else if (state_q == RESP)          to_cnt <= to_cnt + 1'b1;
      if (state_q == RESP) begin
        if (bus.bus_rvalid) begin
          rdata_q <= (cap_write || bus.bus_err) ? 32'd0 : ld_ext;
          err_q   <= bus.bus_err;
        end else if (to_hit) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Reset gates stall so the pipeline is released the moment an op aborts.
  assign stall       = req_valid & (state_q != DONE) & ~reset;
  assign rdata_valid = (state_q == DONE);
  assign rdata       = rdata_q;
  assign err         = err_q;

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_wr    = cap_write;
  assign bus.bus_addr  = {cap_addr[31:2], 2'b00};
  assign bus.bus_wstrb = cap_write ? wstrb_of(cap_width, cap_addr[1:0]) : 4'b0000;
  assign bus.bus_wdata = cap_wdata;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
module tb_dmem_bus_adapter;
  import mem_pkg::*;

  localparam int RESP_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_sign_ext;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, err;
  logic [31:0] rdata;

  dmem_bus_adapter_if bus();

  dmem_bus_adapter #(.RESP_TIMEOUT(RESP_TIMEOUT), .TO_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_width    (req_width),
    .req_sign_ext (req_sign_ext),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .err          (err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_rdata = 0;
  logic        last_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the addressed bytes by shifting, then extend.
  function automatic logic [31:0] ref_load(input logic [1:0] w, input bit sx,
                                           input logic [31:0] a, input logic [31:0] raw);
    int nb;
    logic [31:0] v;
    nb = (w == memWidth1) ? 1 : (w == memWidth2) ? 2 : 4;
    if (nb == 4) return raw;
    v = raw >> (8 * (a % 4));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = v & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // Reference: a run of nb ones placed at the byte offset.
  function automatic logic [3:0] ref_strb(input bit wr, input logic [1:0] w, input logic [31:0] a);
    int nb;
    int m;
    if (!wr) return 4'b0000;
    nb = (w == memWidth1) ? 1 : (w == memWidth2) ? 2 : 4;
    m  = ((1 << nb) - 1) << (a % 4);
    return 4'(m);
  endfunction

  // One complete op. gd = grant delay, rd = response delay (rd < 0: never respond).
  task automatic op(input bit w, input logic [1:0] wd, input bit sx,
                    input logic [31:0] a, input logic [31:0] wdat,
                    input int gd, input int rd, input logic [31:0] raw, input bit be);
    logic [31:0] e_rd;
    logic        e_err;
    int          n;
    req_valid = 1; req_write = w; req_width = wd; req_sign_ext = sx;
    req_addr = a; req_wdata = wdat;
    #1;
    chk("c0_stall", stall, 1);
    chk("c0_bus_req", bus.bus_req, 0);
    chk("c0_rvalid_pulse", rdata_valid, 0);
    chk("c0_rdata_hold", rdata, last_rdata);
    chk("c0_err_hold", err, last_err);
    step();
    for (int g = 0; g <= gd; g++) begin
      if (g == gd) bus.bus_gnt = 1;
      #1;
      chk("req_bus_req", bus.bus_req, 1);
      chk("req_bus_wr", bus.bus_wr, w);
      chk("req_bus_addr", bus.bus_addr, {a[31:2], 2'b00});
      chk("req_wstrb", bus.bus_wstrb, ref_strb(w, wd, a));
      chk("req_wdata", bus.bus_wdata, wdat);
      chk("req_stall", stall, 1);
      // captured fields must not follow the MEM stage any more
      req_addr = $urandom; req_wdata = $urandom; req_write = ~w;
      req_width = 2'($urandom); req_sign_ext = 1'($urandom);
      step();
      bus.bus_gnt = 0;
    end
    if (rd < 0) begin
      e_rd = 0; e_err = 1; n = 0;
      while (1) begin
        #1;
        if (rdata_valid) break;
        if (n == 0) chk("to_bus_req", bus.bus_req, 0);
        n++;
        if (n > 400) begin chk("to_bound", 0, 1); break; end
        step();
      end
      chk("to_len", n, RESP_TIMEOUT);
    end else begin
      e_err = be;
      e_rd  = (w || be) ? 32'd0 : ref_load(wd, sx, a, raw);
      for (int r = 0; r <= rd; r++) begin
        if (r == rd) begin bus.bus_rvalid = 1; bus.bus_rdata = raw; bus.bus_err = be; end
        else bus.bus_rdata = $urandom;
        #1;
        chk("resp_bus_req", bus.bus_req, 0);
        chk("resp_rvalid", rdata_valid, 0);
        chk("resp_stall", stall, 1);
        step();
        bus.bus_rvalid = 0; bus.bus_err = 0; bus.bus_rdata = $urandom;
      end
      #1;
    end
    chk("done_rvalid", rdata_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_rdata", rdata, e_rd);
    chk("done_err", err, e_err);
    chk("done_bus_req", bus.bus_req, 0);
    last_rdata = e_rd; last_err = e_err;
    step();
    req_valid = 0;
  endtask

  initial begin
    logic [1:0]  wd;
    logic [31:0] a;
    reset = 1; req_valid = 0; req_write = 0; req_width = 0; req_sign_ext = 0;
    req_addr = 0; req_wdata = 0;
    bus.bus_gnt = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0; bus.bus_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus.bus_req, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wstrb", bus.bus_wstrb, 0);
    step();
    reset = 0;
    step();

    op(0, memWidth4, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0);
    op(0, memWidth1, 1, 32'h203, 32'h0, 0, 0, 32'h80112233, 0);
    op(0, memWidth1, 0, 32'h203, 32'h0, 0, 0, 32'h80112233, 0);
    op(0, memWidth2, 1, 32'h202, 32'h0, 0, 0, 32'h80112233, 0);
    op(1, memWidth2, 0, 32'h106, 32'hABCD0000, 5, 1, 32'h12345678, 0);
    op(0, memWidth4, 0, 32'h040, 32'h0, 1, 2, 32'hCAFEF00D, 1);
    op(0, memWidth4, 0, 32'h044, 32'h0, 0, -1, 32'h0, 0);

    // late response after timeout, seen in IDLE
    bus.bus_rvalid = 1; bus.bus_rdata = 32'h55AA55AA;
    step();
    bus.bus_rvalid = 0;
    #1;
    chk("late_rvalid", rdata_valid, 0);
    chk("late_rdata", rdata, last_rdata);

    // randomized back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      wd = 2'($urandom_range(0, 2));
      a  = $urandom;
      if (wd == memWidth2) a[0] = 1'b0;
      if (wd == memWidth4) a[1:0] = 2'b00;
      op(1'($urandom), wd, 1'($urandom), a, $urandom,
         $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
         ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) step();
    end

    // reset in RESP aborts the op
    req_valid = 1; req_write = 0; req_width = memWidth4; req_sign_ext = 0;
    req_addr = 32'h300; req_wdata = 0;
    step();
    bus.bus_gnt = 1;
    step();
    bus.bus_gnt = 0;
    #1;
    chk("pre_rst_stall", stall, 1);
    reset = 1;
    #1;
    chk("abort_bus_req", bus.bus_req, 0);
    chk("abort_stall", stall, 0);
    chk("abort_rvalid", rdata_valid, 0);
    step();
    reset = 0; req_valid = 0;
    bus.bus_rvalid = 1; bus.bus_rdata = 32'h11112222;
    step();
    bus.bus_rvalid = 0;
    #1;
    chk("post_rst_rvalid", rdata_valid, 0);
    step();
    chk("post_rst_rvalid2", rdata_valid, 0);
    chk("post_rst_rdata", rdata, 0);
    chk("post_rst_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_bus_adapter.md
Name: dmem_bus_adapter

Overview:
- Data-memory bus stage directly downstream of the data-memory alignment/exception stage.
- Accepts a lane-aligned load/store request from the MEM stage, derives byte strobes, runs one transaction on the valid/grant/response data bus, and returns the selected load data sign- or zero-extended.
- Holds the pipeline with `stall` until the transaction completes. Covers bus error and response timeout.

Parameters:
- `RESP_TIMEOUT`, 255: maximum cycles spent in RESP waiting for `bus_rvalid` before forcing an error completion.
- `TO_W`, 8: width of the timeout counter; must satisfy 2^`TO_W` > `RESP_TIMEOUT`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: MEM stage has a memory op. Driven low by the MEM stage when that stage's address exception is set.
- `req_write` in 1: 1 = store, 0 = load.
- `req_width` in 2: `memWidth1`/`memWidth2`/`memWidth4` from the shared package.
- `req_sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address, already alignment-checked.
- `req_wdata` in 32: store data, already placed in its byte lane.
- `stall` out 1: hold the pipeline.
- `rdata_valid` out 1: one-cycle pulse when the op completes.
- `rdata` out 32: extended load data (0 for stores).
- `err` out 1: completion was a bus error or timeout; valid with `rdata_valid`.
- `bus_req` out 1: request valid.
- `bus_wr` out 1: write request.
- `bus_addr` out 32: word address, `{req_addr[31:2], 2'b00}`.
- `bus_wstrb` out 4: byte strobes; 0 for reads.
- `bus_wdata` out 32: write data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: response (read data or write acknowledge).
- `bus_rdata` in 32: read data.
- `bus_err` in 1: response is an error; qualified by `bus_rvalid`.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0. This includes `bus_req`, `rdata`, `rdata_valid`, `err`, and the timeout counter.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - On `req_valid`=1, capture `req_*` into registers and go to REQ.
  - `stall` = `req_valid`, combinational, so the pipeline holds in the acceptance cycle.
- REQ:
  - `bus_req`=1, with `bus_*` driven from captured registers and held stable until `bus_gnt`.
  - On `bus_gnt` go to RESP and clear the timeout counter.
  - A same-cycle `bus_gnt` and `bus_rvalid` is not legal; the response is taken no earlier than the cycle after grant.
- RESP:
  - `bus_req`=0; the counter increments each cycle.
  - On `bus_rvalid`, register the result and go to DONE:
    - `rdata` = extend(`bus_rdata`) for loads, 0 for stores.
    - `err` = `bus_err`; `rdata` forced to 0 when `bus_err`=1.
  - If the counter reaches `RESP_TIMEOUT` without `bus_rvalid`: go to DONE with `err`=1, `rdata`=0.
  - A late `bus_rvalid` arriving after timeout while in IDLE/REQ is ignored.
- DONE:
  - `rdata_valid`=1 and `stall`=0 for exactly one cycle, then go to IDLE.
  - `rdata`/`err` are held until the next DONE.
- `stall` = `req_valid` & (state != DONE). A new request is never accepted in DONE; the next op is seen in IDLE on the following cycle.
- Captured fields are immune to `req_*` changes after acceptance. The transaction always completes once accepted.
- Strobes:
  - Word: 1111.
  - Half: `addr[1]` ? 1100 : 0011.
  - Byte: 0001 << `addr[1:0]`.
  - Reads: 0000.
- Load extraction:
  - Byte: lane = `bus_rdata[8*addr[1:0] +: 8]`.
  - Half: `addr[1]` ? `[31:16]` : `[15:0]`.
  - Word: unchanged.
  - Extension uses the top bit of the lane when `req_sign_ext`, else zeros.
- Minimum latency: `req_valid` at cycle 0, gnt at cycle 1, rvalid at cycle 2, `rdata_valid` at cycle 3. `stall` is high in cycles 0–2.
- Reset asserted mid-transaction aborts: `bus_req` drops immediately and no `rdata_valid` is produced.

Decomposition:
- Shared package `mem_pkg`:
  - `memWidth1`=2'b00, `memWidth2`=2'b01, `memWidth4`=2'b10.
  - State enum `dbus_state_t` {IDLE, REQ, RESP, DONE}.
- One natural sub-module: `load_extend` (combinational). Inputs: width, sign_ext, addr[1:0], raw 32-bit word. Output: extended 32-bit value. Shared with any future uncached load path.

Test Plan:
- Load word at 0x100; gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF. Expect `bus_addr`=0x100, `wstrb`=0000, `rdata`=0xDEADBEEF, `rdata_valid` at cycle 3, `stall` high for cycles 0–2.
- Signed byte load at 0x203 with `bus_rdata`=0x80112233 → `rdata`=0xFFFFFF80. Same with `req_sign_ext`=0 → 0x00000080. Half load at 0x202, signed → 0xFFFF8011.
- Store half at 0x106, `wdata`=0xABCD0000; gnt delayed 5 cycles. Expect `bus_req` and all `bus_*` stable for 5 cycles, `wstrb`=1100, `bus_addr`=0x104, `rdata`=0, `err`=0.
- `bus_rvalid` with `bus_err`=1 on a load → `err`=1, `rdata`=0, single `rdata_valid` pulse. No rvalid for 255 cycles in RESP → timeout completion with `err`=1.
- Back-to-back ops: `req_valid` held with new fields after DONE → second op captured in IDLE on the following cycle with the new address. `req_*` toggled during REQ → bus fields unchanged.
- Assert `reset` while in RESP → `bus_req`, `stall`, `rdata_valid` all 0 immediately. A `bus_rvalid` arriving after reset produces no completion.
